// File: rtl/imdct_ola_reader.sv
// Drains the IMDCT result RAM, overlap-adds against the overlap RAM, streams
// saturated samples over valid/ready and saves the frame's second half as the next overlap.
module imdct_ola_reader #(
  parameter int DW = 24,
  parameter int AW = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          tabidx,
  input  logic          first_frame,
  output logic [AW-1:0] ram_raddr_a,
  output logic [AW-1:0] ram_raddr_b,
  output logic          ram_re,
  input  logic [DW-1:0] ram_rdata_a,
  input  logic [DW-1:0] ram_rdata_b,
  output logic [AW-1:0] ovl_raddr,
  input  logic [DW-1:0] ovl_rdata,
  output logic [AW-1:0] ovl_waddr,
  output logic          ovl_we,
  output logic [DW-1:0] ovl_wdata,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e        state_q;
  logic          tab_q;
  logic          first_q;
  logic [AW-1:0] idx_q;
  logic [AW-1:0] addr_a_q;
  logic [AW-1:0] addr_b_q;
  logic          inflight_q;
  logic [1:0]    cnt_q;
  logic [DW-1:0] buf0_q;
  logic [DW-1:0] buf1_q;
  logic          done_q;

  logic [AW-1:0] len_s;
  logic          pop_s;
  logic          push_s;
  logic [2:0]    credit_s;
  logic          issue_s;
  logic          drain_done_s;
  logic [DW:0]   sum_s;
  logic [DW-1:0] sat_s;

  function automatic logic [DW-1:0] sat_f(input logic [DW:0] v);
    if (v[DW] != v[DW-1]) begin
      return v[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    end else begin
      return v[DW-1:0];
    end
  endfunction

  // Credit = samples already owed to the FIFO after this cycle's pop; a read may only
  // be issued while the FIFO is guaranteed a free slot when its data returns.
  always_comb begin
    len_s        = tab_q ? AW'(256) : AW'(32);
    pop_s        = (cnt_q != 2'd0) && out_ready;
    push_s       = inflight_q;
    credit_s     = {1'b0, cnt_q} + {2'b00, inflight_q} - {2'b00, pop_s};
    issue_s      = (state_q == S_RUN) && (idx_q < len_s) && (credit_s < 3'd2);
    drain_done_s = (state_q == S_DRAIN) && !inflight_q && (credit_s == 3'd0);
    sum_s        = {ram_rdata_a[DW-1], ram_rdata_a} +
                   (first_q ? {(DW+1){1'b0}} : {ovl_rdata[DW-1], ovl_rdata});
    sat_s        = sat_f(sum_s);
  end

  // Address outputs follow the live index while issuing and hold otherwise.
  always_comb begin
    ram_re      = issue_s;
    ram_raddr_a = issue_s ? idx_q : addr_a_q;
    ram_raddr_b = issue_s ? (idx_q + len_s) : addr_b_q;
    ovl_raddr   = ram_raddr_a;
    ovl_we      = inflight_q;
    ovl_waddr   = addr_a_q;
    ovl_wdata   = inflight_q ? ram_rdata_b : {DW{1'b0}};
    out_data    = buf0_q;
    out_valid   = (cnt_q != 2'd0);
    busy        = (state_q != S_IDLE);
    done        = done_q;
  end

  // Frame sequencing: start latch, read issue and completion pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      tab_q      <= 1'b0;
      first_q    <= 1'b0;
      idx_q      <= {AW{1'b0}};
      addr_a_q   <= {AW{1'b0}};
      addr_b_q   <= {AW{1'b0}};
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      inflight_q <= issue_s;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            tab_q   <= tabidx;
            first_q <= first_frame;
            idx_q   <= {AW{1'b0}};
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          if (issue_s) begin
            idx_q    <= idx_q + AW'(1);
            addr_a_q <= idx_q;
            addr_b_q <= idx_q + len_s;
            if (idx_q == (len_s - AW'(1))) begin
              state_q <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (drain_done_s) begin
            state_q <= S_IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Two-entry output FIFO; entry 0 is the registered output sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= 2'd0;
      buf0_q <= {DW{1'b0}};
      buf1_q <= {DW{1'b0}};
    end else begin
      case ({push_s, pop_s})
        2'b11: begin
          if (cnt_q == 2'd1) begin
            buf0_q <= sat_s;
          end else begin
            buf0_q <= buf1_q;
            buf1_q <= sat_s;
          end
        end
        2'b10: begin
          if (cnt_q == 2'd0) begin
            buf0_q <= sat_s;
          end else begin
            buf1_q <= sat_s;
          end
          cnt_q <= cnt_q + 2'd1;
        end
        2'b01: begin
          buf0_q <= buf1_q;
          cnt_q  <= cnt_q - 2'd1;
        end
        default: begin
          cnt_q <= cnt_q;
        end
      endcase
    end
  end

endmodule
